// File: rtl/ddr_pkg.sv
// Shared constants, types and the lane-to-byte mask helper for the DDR write coalescer.
package ddr_pkg;

    localparam int         LANES      = 8;
    localparam int         LINE_W     = 128;
    localparam int         MASK_W     = 16;
    localparam logic [2:0] APP_CMD_WR = 3'b000;

    typedef logic [20:0] line_addr_t;
    typedef logic [2:0]  lane_t;

    // A lane that was never written masks both of its bytes (mask bit 1 = byte not written).
    function automatic logic [MASK_W-1:0] expand_mask(input logic [LANES-1:0] lane_valid);
        logic [MASK_W-1:0] mask;
        mask = {MASK_W{1'b1}};
        for (int i = 0; i < LANES; i++) begin
            mask[2*i +: 2] = {2{~lane_valid[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/write_line_buffer.sv
// FILL stage: one partially assembled DDR line with per-lane valid bits.
// The view_* outputs show the line as it would look with the current beat merged in.
module write_line_buffer
    import ddr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              merge,
    input  logic [20:0]       beat_line,
    input  logic [2:0]        beat_lane,
    input  logic [15:0]       beat_data,
    output logic [20:0]       fill_line,
    output logic [LANES-1:0]  fill_valid,
    output logic [20:0]       view_line,
    output logic [LANES-1:0]  view_valid,
    output logic [LINE_W-1:0] view_data,
    output logic [MASK_W-1:0] view_mask
);

    line_addr_t        line_r;
    logic [LINE_W-1:0] data_r;
    logic [LANES-1:0]  valid_r;
    logic [LINE_W-1:0] placed_data_s;
    logic [LANES-1:0]  lane_bit_s;

    // Beat data dropped into its lane of the stored line, plus the lane's one-hot.
    always_comb begin
        placed_data_s = data_r;
        placed_data_s[{beat_lane, 4'b0000} +: 16] = beat_data;
        lane_bit_s = {{(LANES-1){1'b0}}, 1'b1} << beat_lane;
    end

    // Merged view used both for the handoff contents and for the stored update.
    always_comb begin
        if (merge) begin
            view_line  = beat_line;
            view_valid = valid_r | lane_bit_s;
            view_data  = placed_data_s;
        end else begin
            view_line  = line_r;
            view_valid = valid_r;
            view_data  = data_r;
        end
        view_mask = expand_mask(view_valid);
    end

    // Storage update: a new line replaces, a handoff empties, a matching beat merges.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_r  <= 21'd0;
            data_r  <= {LINE_W{1'b0}};
            valid_r <= {LANES{1'b0}};
        end else if (load) begin
            line_r  <= beat_line;
            data_r  <= placed_data_s;
            valid_r <= lane_bit_s;
        end else if (clear) begin
            valid_r <= {LANES{1'b0}};
        end else if (merge) begin
            line_r  <= view_line;
            data_r  <= view_data;
            valid_r <= view_valid;
        end
    end

    assign fill_line  = line_r;
    assign fill_valid = valid_r;

endmodule

// File: rtl/ddr_write_coalescer.sv
// Packs 16-bit word writes into 128-bit masked MIG write commands (single ui clock).
// Optional idle flush of partial lines is enabled by defining DDR_COALESCE_TIMEOUT_EN.
module ddr_write_coalescer
    import ddr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int APP_ADDR_W     = 27
) (
    input  logic                  receiver_clk,
    input  logic                  receiver_rst,
    input  logic                  receiver_axis_tvalid,
    output logic                  receiver_axis_tready,
    input  logic [15:0]           receiver_axis_tdata,
    input  logic [23:0]           receiver_axis_taddr,
    input  logic                  flush_in,
    output logic [APP_ADDR_W-1:0] app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [LINE_W-1:0]     app_wdf_data,
    output logic [MASK_W-1:0]     app_wdf_mask,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    input  logic                  app_wdf_rdy,
    output logic                  writer_idle
);

    line_addr_t        beat_line_s;
    lane_t             beat_lane_s;
    logic [20:0]       fill_line_s;
    logic [LANES-1:0]  fill_valid_s;
    logic [20:0]       view_line_s;
    logic [LANES-1:0]  view_valid_s;
    logic [LINE_W-1:0] view_data_s;
    logic [MASK_W-1:0] view_mask_s;

    logic fill_empty_s, fill_full_s, line_match_s, issue_busy_s;
    logic tready_s, accept_s, merge_s, newline_s, view_nonempty_s;
    logic flush_act_s, timeout_hit_s, handoff_s, load_s, clear_s;
    logic fill_empty_next_s, issue_busy_next_s;

    logic [APP_ADDR_W-1:0] addr_r;
    logic [LINE_W-1:0]     data_r;
    logic [MASK_W-1:0]     mask_r;
    logic                  cmd_pend_r, data_pend_r, flush_pend_r, writer_idle_r;

    assign beat_line_s = receiver_axis_taddr[23:3];
    assign beat_lane_s = receiver_axis_taddr[2:0];

    assign fill_empty_s    = (fill_valid_s == {LANES{1'b0}});
    assign fill_full_s     = &fill_valid_s;
    assign line_match_s    = fill_empty_s | (beat_line_s == fill_line_s);
    assign issue_busy_s    = cmd_pend_r | data_pend_r;
    assign tready_s        = ~receiver_rst & ~fill_full_s & ~(~line_match_s & issue_busy_s);
    assign accept_s        = receiver_axis_tvalid & tready_s;
    assign merge_s         = accept_s & line_match_s;
    assign newline_s       = accept_s & ~line_match_s;
    assign view_nonempty_s = |view_valid_s;
    assign flush_act_s     = flush_pend_r | flush_in;

    // A full line also leaves here when it had to wait for ISSUE to drain.
    assign handoff_s = ~issue_busy_s & view_nonempty_s &
                       ((&view_valid_s) | newline_s | flush_act_s | timeout_hit_s);
    assign load_s    = handoff_s & newline_s;
    assign clear_s   = handoff_s & ~newline_s;

    assign fill_empty_next_s = load_s ? 1'b0 : (clear_s ? 1'b1 : ~view_nonempty_s);
    assign issue_busy_next_s = handoff_s | (cmd_pend_r & ~app_rdy) | (data_pend_r & ~app_wdf_rdy);

    write_line_buffer u_fill (
        .clk        (receiver_clk),
        .rst        (receiver_rst),
        .load       (load_s),
        .clear      (clear_s),
        .merge      (merge_s),
        .beat_line  (beat_line_s),
        .beat_lane  (beat_lane_s),
        .beat_data  (receiver_axis_tdata),
        .fill_line  (fill_line_s),
        .fill_valid (fill_valid_s),
        .view_line  (view_line_s),
        .view_valid (view_valid_s),
        .view_data  (view_data_s),
        .view_mask  (view_mask_s)
    );

`ifdef DDR_COALESCE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] idle_cnt_r;

    // Idle counter: restarts on every accepted beat and saturates once the limit is reached.
    always_ff @(posedge receiver_clk) begin
        if (receiver_rst) begin
            idle_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s | fill_empty_s) begin
            idle_cnt_r <= {CNT_W{1'b0}};
        end else if (idle_cnt_r < CNT_W'(TIMEOUT_CYCLES - 1)) begin
            idle_cnt_r <= idle_cnt_r + CNT_W'(1);
        end
    end

    assign timeout_hit_s = ~fill_empty_s & ~accept_s & (idle_cnt_r >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
    assign timeout_hit_s    = 1'b0;
`endif

    // ISSUE stage: command and write data retire independently on their own handshakes.
    always_ff @(posedge receiver_clk) begin
        if (receiver_rst) begin
            addr_r        <= {APP_ADDR_W{1'b0}};
            data_r        <= {LINE_W{1'b0}};
            mask_r        <= {MASK_W{1'b1}};
            cmd_pend_r    <= 1'b0;
            data_pend_r   <= 1'b0;
            flush_pend_r  <= 1'b0;
            writer_idle_r <= 1'b1;
        end else begin
            if (handoff_s) begin
                addr_r      <= APP_ADDR_W'({3'b000, view_line_s, 3'b000});
                data_r      <= view_data_s;
                mask_r      <= view_mask_s;
                cmd_pend_r  <= 1'b1;
                data_pend_r <= 1'b1;
            end else begin
                cmd_pend_r  <= cmd_pend_r & ~app_rdy;
                data_pend_r <= data_pend_r & ~app_wdf_rdy;
            end
            // A flush request is dropped once nothing is left to hand off.
            flush_pend_r  <= flush_act_s & ~handoff_s & view_nonempty_s;
            writer_idle_r <= fill_empty_next_s & ~issue_busy_next_s;
        end
    end

    assign receiver_axis_tready = tready_s;
    assign app_addr             = addr_r;
    assign app_cmd              = APP_CMD_WR;
    assign app_en               = cmd_pend_r;
    assign app_wdf_data         = data_r;
    assign app_wdf_mask         = mask_r;
    assign app_wdf_wren         = data_pend_r;
    assign app_wdf_end          = data_pend_r;
    assign writer_idle          = writer_idle_r;

endmodule
